// File: rtl/sparse_block_sequencer_pkg.sv
// rtl/sparse_block_sequencer_pkg.sv - shared widths, packet/activation types and sequencer states
package sparse_block_sequencer_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int PSUM_WIDTH = 20;
  localparam int PSUM_MAX   = (1 << (PSUM_WIDTH - 1)) - 1;
  localparam int PSUM_MIN   = -(1 << (PSUM_WIDTH - 1));

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] val_1;
    logic signed [DATA_WIDTH-1:0] val_0;
    logic [1:0]                   idx_1;
    logic [1:0]                   idx_0;
  } sparse_packet_t;

  typedef logic [3:0][DATA_WIDTH-1:0] activation_vec_t;

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_FLUSH, SEQ_OUT} seq_state_e;

  function automatic logic signed [PROD_WIDTH-1:0] sext_prod(input logic signed [DATA_WIDTH-1:0] x);
    return {{(PROD_WIDTH - DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
  endfunction

endpackage

// File: rtl/sparse_dot2_stage.sv
// rtl/sparse_dot2_stage.sv - stage 1: pick two activations by index and multiply by the packed weights
module sparse_dot2_stage
  import sparse_block_sequencer_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  sparse_packet_t               pkt,
  input  activation_vec_t              act,
  output logic                         out_valid,
  output logic signed [PROD_WIDTH-1:0] p0,
  output logic signed [PROD_WIDTH-1:0] p1
);

  logic signed [DATA_WIDTH-1:0] a0;
  logic signed [DATA_WIDTH-1:0] a1;

  // Equal indices simply read the same activation twice.
  assign a0 = $signed(act[pkt.idx_0]);
  assign a1 = $signed(act[pkt.idx_1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      p0        <= '0;
      p1        <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        p0 <= sext_prod(pkt.val_0) * sext_prod(a0);
        p1 <= sext_prod(pkt.val_1) * sext_prod(a1);
      end
    end
  end

endmodule

// File: rtl/sparse_block_sequencer.sv
// rtl/sparse_block_sequencer.sv - one 2:4-sparse dot-product job: lock-step intake, MAC pipeline, saturated result
module sparse_block_sequencer
  import sparse_block_sequencer_pkg::*;
#(
  parameter int MAX_BLOCKS = 256,
  parameter int CNT_WIDTH  = $clog2(MAX_BLOCKS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic [CNT_WIDTH-1:0]         num_blocks_i,
  output logic                         busy_o,
  input  logic                         w_valid_i,
  output logic                         w_ready_o,
  input  sparse_packet_t               w_pkt_i,
  input  logic                         a_valid_i,
  output logic                         a_ready_o,
  input  activation_vec_t              a_vec_i,
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic signed [PSUM_WIDTH-1:0] res_data_o,
  output logic                         res_sat_o
);

  localparam int SUM_WIDTH = PSUM_WIDTH + 2;

  seq_state_e                   state;
  logic [CNT_WIDTH-1:0]         num_blocks;
  logic [CNT_WIDTH-1:0]         issued;
  logic signed [PSUM_WIDTH-1:0] acc;
  logic                         sat;
  logic                         fire;
  logic                         s1_valid;
  logic signed [PROD_WIDTH-1:0] p0;
  logic signed [PROD_WIDTH-1:0] p1;
  logic signed [SUM_WIDTH-1:0]  sum;
  logic signed [PSUM_WIDTH-1:0] acc_next;
  logic                         clamp;

  // Both streams advance together or not at all.
  assign fire      = (state == SEQ_RUN) && (issued < num_blocks) && w_valid_i && a_valid_i;
  assign w_ready_o = fire;
  assign a_ready_o = fire;
  assign busy_o    = (state != SEQ_IDLE);
  assign res_data_o = acc;
  assign res_sat_o  = sat;

  sparse_dot2_stage u_stage (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (fire),
    .pkt       (w_pkt_i),
    .act       (a_vec_i),
    .out_valid (s1_valid),
    .p0        (p0),
    .p1        (p1)
  );

  // Two guard bits so acc + p0 + p1 cannot wrap before the clamp.
  always_comb begin
    sum = {{2{acc[PSUM_WIDTH-1]}}, acc}
        + {{(SUM_WIDTH - PROD_WIDTH){p0[PROD_WIDTH-1]}}, p0}
        + {{(SUM_WIDTH - PROD_WIDTH){p1[PROD_WIDTH-1]}}, p1};
    clamp    = 1'b0;
    acc_next = sum[PSUM_WIDTH-1:0];
    if (sum > SUM_WIDTH'(PSUM_MAX)) begin
      clamp    = 1'b1;
      acc_next = PSUM_WIDTH'(PSUM_MAX);
    end else if (sum < SUM_WIDTH'(PSUM_MIN)) begin
      clamp    = 1'b1;
      acc_next = PSUM_WIDTH'(PSUM_MIN);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SEQ_IDLE;
      num_blocks  <= '0;
      issued      <= '0;
      acc         <= '0;
      sat         <= 1'b0;
      res_valid_o <= 1'b0;
    end else begin
      if (s1_valid) begin
        acc <= acc_next;
        if (clamp) sat <= 1'b1;
      end
      if (fire) issued <= issued + CNT_WIDTH'(1);
      case (state)
        SEQ_IDLE: begin
          if (start_i) begin
            num_blocks <= num_blocks_i;
            issued     <= '0;
            acc        <= '0;
            sat        <= 1'b0;
            // An empty job skips intake and goes straight to the drain check.
            state      <= (num_blocks_i == '0) ? SEQ_FLUSH : SEQ_RUN;
          end
        end
        SEQ_RUN: begin
          if (issued == num_blocks) state <= SEQ_FLUSH;
        end
        SEQ_FLUSH: begin
          if (!s1_valid) begin
            state       <= SEQ_OUT;
            res_valid_o <= 1'b1;
          end
        end
        SEQ_OUT: begin
          if (res_ready_i) begin
            state       <= SEQ_IDLE;
            res_valid_o <= 1'b0;
          end
        end
        default: state <= SEQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_block_sequencer.sv
// tb/tb_sparse_block_sequencer.sv - table, directed and random jobs checked against a behavioural model
module tb_sparse_block_sequencer;
  import sparse_block_sequencer_pkg::*;

  localparam int CW = 9;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         start_i;
  logic [CW-1:0]                num_blocks_i;
  logic                         busy_o;
  logic                         w_valid_i;
  logic                         w_ready_o;
  sparse_packet_t               w_pkt_i;
  logic                         a_valid_i;
  logic                         a_ready_o;
  activation_vec_t              a_vec_i;
  logic                         res_valid_o;
  logic                         res_ready_i;
  logic signed [PSUM_WIDTH-1:0] res_data_o;
  logic                         res_sat_o;

  sparse_block_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .num_blocks_i (num_blocks_i),
    .busy_o       (busy_o),
    .w_valid_i    (w_valid_i),
    .w_ready_o    (w_ready_o),
    .w_pkt_i      (w_pkt_i),
    .a_valid_i    (a_valid_i),
    .a_ready_o    (a_ready_o),
    .a_vec_i      (a_vec_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_data_o   (res_data_o),
    .res_sat_o    (res_sat_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  sparse_packet_t  wq[$];
  activation_vec_t aq[$];

  typedef struct {
    string           name;
    int              n;
    sparse_packet_t  pkt;
    activation_vec_t act;
    int              exp_res;
    bit              exp_sat;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic activation_vec_t mk_act(input int a0, input int a1, input int a2, input int a3);
    activation_vec_t v;
    v[0] = a0[7:0]; v[1] = a1[7:0]; v[2] = a2[7:0]; v[3] = a3[7:0];
    return v;
  endfunction

  function automatic sparse_packet_t mk_pkt(input int v0, input int i0, input int v1, input int i1);
    sparse_packet_t p;
    p.val_0 = v0[7:0]; p.idx_0 = i0[1:0]; p.val_1 = v1[7:0]; p.idx_1 = i1[1:0];
    return p;
  endfunction

  function automatic int act_elem(input activation_vec_t v, input logic [1:0] i);
    logic signed [7:0] x;
    x = v[i];
    return int'(x);
  endfunction

  // Reference: exact integer sum, clamped to the PSUM range after every block.
  function automatic void model(input int n, output int res, output bit sat);
    longint acc;
    acc = 0;
    sat = 1'b0;
    for (int i = 0; i < n; i++) begin
      acc += int'(wq[i].val_0) * act_elem(aq[i], wq[i].idx_0)
           + int'(wq[i].val_1) * act_elem(aq[i], wq[i].idx_1);
      if (acc > 524287)  begin acc = 524287;  sat = 1'b1; end
      if (acc < -524288) begin acc = -524288; sat = 1'b1; end
    end
    res = int'(acc);
  endfunction

  task automatic run_job(input string tag, input int n, input bit w_rand, input bit a_toggle,
                         output int res, output bit sat);
    int  idx;
    int  cyc;
    bit  took;
    bit  bad_hs;
    @(negedge clk);
    start_i      = 1'b1;
    num_blocks_i = n[CW-1:0];
    @(posedge clk); #1;
    start_i = 1'b0;
    idx = 0; cyc = 0; bad_hs = 1'b0;
    while (idx < n && cyc < 5000) begin
      w_valid_i = w_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      a_valid_i = a_toggle ? cyc[0] : (w_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
      w_pkt_i   = wq[idx];
      a_vec_i   = aq[idx];
      @(negedge clk);
      if (w_ready_o !== (w_valid_i && a_valid_i) || a_ready_o !== w_ready_o) bad_hs = 1'b1;
      took = w_ready_o;
      @(posedge clk); #1;
      if (took) idx++;
      cyc++;
    end
    w_valid_i = 1'b0;
    a_valid_i = 1'b0;
    chk({tag, " handshake"}, int'(bad_hs), 0);
    chk({tag, " all blocks accepted"}, idx, n);
    @(negedge clk);
    chk({tag, " res_valid before 1st edge"}, int'(res_valid_o), 0);
    @(posedge clk); @(negedge clk);
    chk({tag, " res_valid after 1st edge"}, int'(res_valid_o), 0);
    @(posedge clk); @(negedge clk);
    chk({tag, " res_valid after 2nd edge"}, int'(res_valid_o), 1);
    res = int'(res_data_o);
    sat = res_sat_o;
    res_ready_i = 1'b1;
    @(posedge clk); #1;
    res_ready_i = 1'b0;
    @(negedge clk);
    chk({tag, " res_valid drops"}, int'(res_valid_o), 0);
    chk({tag, " idle after result"}, int'(busy_o), 0);
  endtask

  task automatic fill(input int n, input sparse_packet_t p, input activation_vec_t a);
    wq.delete(); aq.delete();
    for (int i = 0; i < n; i++) begin
      wq.push_back(p);
      aq.push_back(a);
    end
  endtask

  initial begin
    int  res;
    bit  sat;
    int  mres;
    bit  msat;
    int  hold_data;
    bit  moved;
    rst = 1'b1; start_i = 1'b0; num_blocks_i = '0;
    w_valid_i = 1'b0; a_valid_i = 1'b0; w_pkt_i = '0; a_vec_i = '0; res_ready_i = 1'b0;

    tbl.push_back('{"t1 single", 1, mk_pkt(3, 1, -2, 3), mk_act(10, 20, 30, 40), -20, 1'b0});
    tbl.push_back('{"t2 four", 4, mk_pkt(1, 0, 1, 1), mk_act(1, 2, 3, 4), 12, 1'b0});
    tbl.push_back('{"t4 pos sat", 40, mk_pkt(-128, 0, -128, 1), mk_act(-128, -128, 0, 0), 524287, 1'b1});
    tbl.push_back('{"t4 next clears sat", 4, mk_pkt(1, 0, 1, 1), mk_act(1, 2, 3, 4), 12, 1'b0});
    tbl.push_back('{"neg sat", 40, mk_pkt(-128, 0, -128, 1), mk_act(127, 127, 0, 0), -524288, 1'b1});
    tbl.push_back('{"max blocks", 256, mk_pkt(1, 2, 0, 3), mk_act(0, 0, 1, 0), 256, 1'b0});
    tbl.push_back('{"same idx", 2, mk_pkt(-7, 3, 5, 3), mk_act(0, 0, 0, -9), 36, 1'b0});

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset busy", int'(busy_o), 0);
    chk("reset w_ready", int'(w_ready_o), 0);
    chk("reset res_valid", int'(res_valid_o), 0);
    chk("reset res_sat", int'(res_sat_o), 0);
    chk("reset res_data", int'(res_data_o), 0);

    foreach (tbl[k]) begin
      fill(tbl[k].n, tbl[k].pkt, tbl[k].act);
      run_job(tbl[k].name, tbl[k].n, 1'b0, 1'b0, res, sat);
      model(tbl[k].n, mres, msat);
      chk({tbl[k].name, " res"}, res, tbl[k].exp_res);
      chk({tbl[k].name, " sat"}, int'(sat), int'(tbl[k].exp_sat));
      chk({tbl[k].name, " model res"}, res, mres);
    end

    // Activation valid toggles while weight valid is held.
    fill(3, mk_pkt(1, 2, 1, 2), mk_act(0, 0, 5, 0));
    run_job("t3 toggle", 3, 1'b0, 1'b1, res, sat);
    chk("t3 res", res, 30);
    chk("t3 sat", int'(sat), 0);

    // Empty job, stalled result, start pulses ignored while busy.
    @(negedge clk);
    start_i = 1'b1; num_blocks_i = '0;
    @(posedge clk); #1 start_i = 1'b0;
    @(negedge clk);
    chk("t5 res_valid after 1 edge", int'(res_valid_o), 0);
    @(posedge clk); @(negedge clk);
    chk("t5 res_valid after 2 edges", int'(res_valid_o), 1);
    chk("t5 res", int'(res_data_o), 0);
    chk("t5 sat", int'(res_sat_o), 0);
    hold_data = int'(res_data_o);
    moved = 1'b0;
    for (int c = 0; c < 5; c++) begin
      start_i = (c == 1);
      num_blocks_i = 9'd3;
      w_valid_i = 1'b1; a_valid_i = 1'b1;
      @(posedge clk); @(negedge clk);
      if (!res_valid_o || int'(res_data_o) != hold_data || res_sat_o || !busy_o || w_ready_o) moved = 1'b1;
    end
    start_i = 1'b0; w_valid_i = 1'b0; a_valid_i = 1'b0;
    chk("t5 stable while stalled", int'(moved), 0);
    res_ready_i = 1'b1;
    @(posedge clk); #1 res_ready_i = 1'b0;
    @(negedge clk);
    chk("t5 res_valid drops", int'(res_valid_o), 0);
    chk("t5 idle, stray start ignored", int'(busy_o), 0);

    // Reset in the middle of a job.
    @(negedge clk);
    start_i = 1'b1; num_blocks_i = 9'd5;
    @(posedge clk); #1;
    start_i = 1'b0;
    w_valid_i = 1'b1; a_valid_i = 1'b1;
    w_pkt_i = mk_pkt(3, 1, -2, 3); a_vec_i = mk_act(10, 20, 30, 40);
    @(posedge clk); #1;
    @(posedge clk); #1;
    w_valid_i = 1'b0; a_valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6 busy", int'(busy_o), 0);
    chk("t6 ready", int'(w_ready_o | a_ready_o), 0);
    chk("t6 res_valid", int'(res_valid_o), 0);
    chk("t6 res_sat", int'(res_sat_o), 0);
    chk("t6 res_data", int'(res_data_o), 0);
    moved = 1'b0;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (res_valid_o || busy_o || res_data_o != 0) moved = 1'b1;
    end
    chk("t6 nothing emitted", int'(moved), 0);
    fill(1, mk_pkt(3, 1, -2, 3), mk_act(10, 20, 30, 40));
    run_job("t6 rerun", 1, 1'b0, 1'b0, res, sat);
    chk("t6 rerun res", res, -20);

    // Random jobs with independent valid stalls.
    for (int j = 0; j < 25; j++) begin
      int n;
      n = $urandom_range(1, 40);
      wq.delete(); aq.delete();
      for (int i = 0; i < n; i++) begin
        wq.push_back(mk_pkt($urandom_range(0, 255), $urandom_range(0, 3),
                            $urandom_range(0, 255), $urandom_range(0, 3)));
        aq.push_back(mk_act($urandom_range(0, 255), $urandom_range(0, 255),
                            $urandom_range(0, 255), $urandom_range(0, 255)));
      end
      run_job($sformatf("rand%0d", j), n, 1'b1, 1'b0, res, sat);
      model(n, mres, msat);
      chk($sformatf("rand%0d res", j), res, mres);
      chk($sformatf("rand%0d sat", j), int'(sat), int'(msat));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
